// File: rtl/mu_dma_master_pkg.sv
// Shared definitions for the memory-unit DMA master: job/access state
// encodings and default sizing parameters.
package mu_dma_master_pkg;

    localparam int DEF_ADDR_W      = 27;
    localparam int DEF_LEN_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_RD,
        ST_WR,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } dma_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP
    } acc_state_e;

endpackage

// File: rtl/mu_dma_master_access.sv
// Single memory-unit access: start/busy handshake with a per-phase timeout
// and a one-cycle start-low gap after completion.
module mu_bus_access
    import mu_dma_master_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic              we,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              mem_start,
    input  logic              mem_busy,
    input  logic [31:0]       mem_q
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    acc_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
            mem_start <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        mem_addr  <= addr;
                        mem_data  <= data;
                        mem_we    <= we;
                        mem_start <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_REQ;
                    end
                end
                // A busy level already present here is taken as the acknowledge.
                S_REQ: begin
                    if (mem_busy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else if (r_cnt == CNT_LAST) begin
                        mem_start <= 1'b0;
                        timeout   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (!mem_busy) begin
                        rdata     <= mem_q;
                        mem_start <= 1'b0;
                        r_state   <= S_GAP;
                    end else if (r_cnt == CNT_LAST) begin
                        mem_start <= 1'b0;
                        timeout   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mu_dma_master.sv
// DMA master for the memory-unit request port: word copy or fill jobs,
// bus arbitration request, and sticky timeout error reporting.
module mu_dma_master
    import mu_dma_master_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_fill,
    input  logic [31:0]       cfg_fill_val,
    input  logic              cfg_go,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_err,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              mem_start,
    input  logic              mem_busy,
    input  logic [31:0]       mem_q
);

    dma_state_e        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [LEN_W-1:0]  r_rem;
    logic              r_fill;
    logic [31:0]       r_fill_val;
    logic [31:0]       r_data;
    logic              r_issued;
    logic              r_acc_go;
    logic [ADDR_W-1:0] r_acc_addr;
    logic [31:0]       r_acc_data;
    logic              r_acc_we;
    logic              w_acc_done;
    logic              w_acc_to;
    logic [31:0]       w_acc_rdata;

    mu_bus_access #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_access (
        .clk       (clk),
        .reset     (reset),
        .go        (r_acc_go),
        .addr      (r_acc_addr),
        .data      (r_acc_data),
        .we        (r_acc_we),
        .done      (w_acc_done),
        .timeout   (w_acc_to),
        .rdata     (w_acc_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_start (mem_start),
        .mem_busy  (mem_busy),
        .mem_q     (mem_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_fill     <= 1'b0;
            r_fill_val <= '0;
            r_data     <= '0;
            r_issued   <= 1'b0;
            r_acc_go   <= 1'b0;
            r_acc_addr <= '0;
            r_acc_data <= '0;
            r_acc_we   <= 1'b0;
            dma_busy   <= 1'b0;
            dma_done   <= 1'b0;
            dma_err    <= 1'b0;
            bus_req    <= 1'b0;
        end else begin
            r_acc_go <= 1'b0;
            dma_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_go) begin
                        r_src      <= cfg_src;
                        r_dst      <= cfg_dst;
                        r_rem      <= cfg_len;
                        r_fill     <= cfg_fill;
                        r_fill_val <= cfg_fill_val;
                        r_issued   <= 1'b0;
                        dma_err    <= 1'b0;
                        dma_busy   <= 1'b1;
                        r_state    <= (cfg_len == '0) ? ST_DONE : ST_ARB;
                    end
                end
                ST_ARB: begin
                    bus_req <= 1'b1;
                    if (bus_req && bus_gnt)
                        r_state <= r_fill ? ST_WR : ST_RD;
                end
                ST_RD: begin
                    if (!r_issued) begin
                        r_acc_go   <= 1'b1;
                        r_acc_addr <= r_src;
                        r_acc_we   <= 1'b0;
                        r_issued   <= 1'b1;
                    end else if (w_acc_to) begin
                        r_state <= ST_ERR;
                    end else if (w_acc_done) begin
                        r_data   <= w_acc_rdata;
                        r_issued <= 1'b0;
                        r_state  <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (!r_issued) begin
                        r_acc_go   <= 1'b1;
                        r_acc_addr <= r_dst;
                        r_acc_data <= r_fill ? r_fill_val : r_data;
                        r_acc_we   <= 1'b1;
                        r_issued   <= 1'b1;
                    end else if (w_acc_to) begin
                        r_state <= ST_ERR;
                    end else if (w_acc_done) begin
                        r_issued <= 1'b0;
                        r_state  <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_src <= r_src + ADDR_W'(1);
                    r_dst <= r_dst + ADDR_W'(1);
                    r_rem <= r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1))
                        r_state <= ST_DONE;
                    else
                        r_state <= r_fill ? ST_WR : ST_RD;
                end
                ST_DONE: begin
                    bus_req  <= 1'b0;
                    dma_done <= 1'b1;
                    dma_busy <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                ST_ERR: begin
                    dma_err  <= 1'b1;
                    bus_req  <= 1'b0;
                    dma_done <= 1'b1;
                    dma_busy <= 1'b0;
                    r_issued <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mu_dma_master.sv
// Directed testbench for mu_dma_master with a behavioural memory unit
// and a grant model with programmable delay.
module tb_mu_dma_master;

    localparam int AW = 27;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_src = '0;
    logic [AW-1:0] cfg_dst = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_fill = 1'b0;
    logic [31:0]   cfg_fill_val = '0;
    logic          cfg_go = 1'b0;
    logic          dma_busy, dma_done, dma_err, bus_req;
    logic          bus_gnt;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          mem_we, mem_start;
    logic          mem_busy;
    logic [31:0]   mem_q;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mu_dma_master #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .reset        (rst),
        .cfg_src      (cfg_src),
        .cfg_dst      (cfg_dst),
        .cfg_len      (cfg_len),
        .cfg_fill     (cfg_fill),
        .cfg_fill_val (cfg_fill_val),
        .cfg_go       (cfg_go),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done),
        .dma_err      (dma_err),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_start    (mem_start),
        .mem_busy     (mem_busy),
        .mem_q        (mem_q)
    );

    // memory unit model: busy 1 cycle after start, held 2 cycles
    logic [31:0]   mem [logic [AW-1:0]];
    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    logic          wwe [$];
    int            rd_n = 0;
    int            ph = 0;
    bit            mute = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_busy <= 1'b0;
            mem_q    <= '0;
            ph       <= 0;
        end else begin
            case (ph)
                0: if (mem_start && !mute) begin
                    mem_busy <= 1'b1;
                    ph       <= 1;
                end
                1: ph <= 2;
                2: begin
                    mem_busy <= 1'b0;
                    if (mem_we) begin
                        wa.push_back(mem_addr);
                        wd.push_back(mem_data);
                        wwe.push_back(mem_we);
                        mem[mem_addr] = mem_data;
                    end else begin
                        rd_n++;
                        mem_q <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    end
                    ph <= 3;
                end
                default: if (!mem_start) ph <= 0;
            endcase
        end
    end

    int gnt_delay = 0;
    int gcnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst || !bus_req) begin
            bus_gnt <= 1'b0;
            gcnt    <= 0;
        end else begin
            gcnt <= gcnt + 1;
            if (gcnt >= gnt_delay) bus_gnt <= 1'b1;
        end
    end

    // protocol monitors
    int            done_cnt = 0, hi_cnt = 0, rise_cnt = 0;
    int            proto_viol = 0, gnt_viol = 0;
    logic          p_start = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [31:0]   p_data = '0;
    logic          p_we = 1'b0;
    always @(posedge clk) begin
        if (dma_done) done_cnt++;
        if (mem_start) hi_cnt++;
        if (mem_start && !p_start) rise_cnt++;
        if (mem_start && !bus_gnt) gnt_viol++;
        if (mem_start && p_start &&
            (mem_addr !== p_addr || mem_data !== p_data || mem_we !== p_we))
            proto_viol++;
        p_start = mem_start;
        p_addr  = mem_addr;
        p_data  = mem_data;
        p_we    = mem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_job(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input logic f,
                          input logic [31:0] v);
        cfg_src      = s;
        cfg_dst      = d;
        cfg_len      = n;
        cfg_fill     = f;
        cfg_fill_val = v;
        cfg_go       = 1'b1;
        @(posedge clk);
        #1;
        cfg_go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk);
            #1;
            if (dma_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic clr_logs();
        wa.delete();
        wd.delete();
        wwe.delete();
        rd_n     = 0;
        done_cnt = 0;
        hi_cnt   = 0;
        rise_cnt = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(dma_busy), 64'd0);
        chk("rst_done", 64'(dma_done), 64'd0);
        chk("rst_err", 64'(dma_err), 64'd0);
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_start", 64'(mem_start), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // copy of three words
        mem[27'h10] = 32'hA;
        mem[27'h11] = 32'hB;
        mem[27'h12] = 32'hC;
        clr_logs();
        go_job(27'h10, 27'hC00420, 16'd3, 1'b0, 32'h0);
        chk("t1_busy", 64'(dma_busy), 64'd1);
        wait_done("t1", 200);
        chk("t1_nwr", 64'(wa.size()), 64'd3);
        chk("t1_nrd", 64'(rd_n), 64'd3);
        if (wa.size() == 3) begin
            chk("t1_a0", 64'(wa[0]), 64'hC00420);
            chk("t1_a1", 64'(wa[1]), 64'hC00421);
            chk("t1_a2", 64'(wa[2]), 64'hC00422);
            chk("t1_d0", 64'(wd[0]), 64'hA);
            chk("t1_d1", 64'(wd[1]), 64'hB);
            chk("t1_d2", 64'(wd[2]), 64'hC);
        end
        chk("t1_err", 64'(dma_err), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", 64'(dma_done), 64'd0);
        chk("t1_ndone", 64'(done_cnt), 64'd1);
        chk("t1_req_off", 64'(bus_req), 64'd0);

        // fill four words
        clr_logs();
        go_job(27'h0, 27'hC00000, 16'd4, 1'b1, 32'hDEADBEEF);
        wait_done("t2", 200);
        chk("t2_busy_at_done", 64'(dma_busy), 64'd0);
        chk("t2_nwr", 64'(wa.size()), 64'd4);
        chk("t2_nrd", 64'(rd_n), 64'd0);
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t2_a%0d", i), 64'(wa[i]), 64'hC00000 + 64'(i));
                chk($sformatf("t2_d%0d", i), 64'(wd[i]), 64'hDEADBEEF);
                chk($sformatf("t2_we%0d", i), 64'(wwe[i]), 64'd1);
            end
        end

        // zero length
        @(posedge clk);
        #1;
        clr_logs();
        go_job(27'h5, 27'h6, 16'd0, 1'b0, 32'h0);
        chk("t3_busy", 64'(dma_busy), 64'd1);
        chk("t3_done_early", 64'(dma_done), 64'd0);
        @(posedge clk);
        #1;
        chk("t3_done_2cyc", 64'(dma_done), 64'd1);
        chk("t3_busy_off", 64'(dma_busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_no_start", 64'(rise_cnt), 64'd0);

        // unresponsive memory -> timeout
        mute = 1'b1;
        clr_logs();
        go_job(27'h10, 27'h20, 16'd2, 1'b0, 32'h0);
        wait_done("t4", 100);
        chk("t4_err", 64'(dma_err), 64'd1);
        chk("t4_start_off", 64'(mem_start), 64'd0);
        chk("t4_start_cycles", 64'(hi_cnt), 64'd16);
        chk("t4_req_off", 64'(bus_req), 64'd0);
        chk("t4_nwr", 64'(wa.size()), 64'd0);
        mute = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_err_sticky", 64'(dma_err), 64'd1);
        go_job(27'h0, 27'h0, 16'd0, 1'b0, 32'h0);
        chk("t4_err_clr", 64'(dma_err), 64'd0);
        wait_done("t4b", 10);

        // reset in the middle of the busy phase
        clr_logs();
        go_job(27'h10, 27'h30, 16'd1, 1'b0, 32'h0);
        for (int i = 0; i < 50 && ph != 2; i++) @(posedge clk);
        chk("t5_reached_wait", 64'(ph), 64'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_start", 64'(mem_start), 64'd0);
        chk("t5_req", 64'(bus_req), 64'd0);
        chk("t5_busy", 64'(dma_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_logs();
        go_job(27'h0, 27'h0, 16'd0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("t5_idle_done", 64'(dma_done), 64'd1);
        chk("t5_no_start", 64'(rise_cnt), 64'd0);

        // address wrap with a late grant
        gnt_delay = 5;
        clr_logs();
        go_job(27'h0, 27'h7FFFFFF, 16'd2, 1'b1, 32'h12345678);
        wait_done("t6", 200);
        chk("t6_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("t6_a0", 64'(wa[0]), 64'h7FFFFFF);
            chk("t6_a1", 64'(wa[1]), 64'h0);
        end
        chk("gnt_viol", 64'(gnt_viol), 64'd0);
        chk("proto_viol", 64'(proto_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
